// File: rtl/centisecond_to_clock_display_if.sv
// Handshake and display bundle between the counter stage and the centisecond-to-clock converter.
interface centisecond_to_clock_display_if #(
   parameter int unsigned COUNT_WIDTH = 40
);
   logic [COUNT_WIDTH-1:0] countIn;
   logic                   convert;
   logic                   busy;
   logic                   done;
   logic [6:0]             centisecondsDisplay;
   logic [5:0]             secondsDisplay;
   logic [5:0]             minutesDisplay;
   logic [4:0]             hoursDisplay;
   logic [COUNT_WIDTH-1:0] daysDisplay;

   modport master (
      output countIn, convert,
      input  busy, done, centisecondsDisplay, secondsDisplay, minutesDisplay,
             hoursDisplay, daysDisplay
   );

   modport slave (
      input  countIn, convert,
      output busy, done, centisecondsDisplay, secondsDisplay, minutesDisplay,
             hoursDisplay, daysDisplay
   );
endinterface

// File: rtl/centisecond_to_clock_display.sv
// Converts a centisecond count into days/hours/minutes/seconds/centiseconds using one
// shared restoring divider run in four chained stages (/100, /60, /60, /24).
module centisecond_to_clock_display #(
   parameter int unsigned COUNT_WIDTH = 40
) (
   input logic                           clockSignal,
   input logic                           reset,
   centisecond_to_clock_display_if.slave bus
);
   typedef enum logic [2:0] {IDLE, DIV100, DIV60S, DIV60M, DIV24, FINISH} state_t;

   localparam logic [6:0] LAST_STEP = 7'(COUNT_WIDTH - 1);

   state_t                 state, state_next;
   logic [COUNT_WIDTH-1:0] quo;
   logic [6:0]             rem, rem_next, divisor, step;
   logic [7:0]             trial;
   logic                   fits, last, busy;
   logic [6:0]             cs_rem;
   logic [5:0]             sec_rem, min_rem;
   logic [4:0]             hr_rem;
   logic                   done_q;
   logic [6:0]             cs_out;
   logic [5:0]             sec_out, min_out;
   logic [4:0]             hr_out;
   logic [COUNT_WIDTH-1:0] day_out;

   always_ff @(posedge clockSignal) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      divisor    = 7'd100;
      busy       = 1'b1;
      last       = (step == LAST_STEP);
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.convert) state_next = DIV100;
         end
         DIV100: if (last) state_next = DIV60S;
         DIV60S: begin
            divisor = 7'd60;
            if (last) state_next = DIV60M;
         end
         DIV60M: begin
            divisor = 7'd60;
            if (last) state_next = DIV24;
         end
         DIV24: begin
            divisor = 7'd24;
            if (last) state_next = FINISH;
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // One restoring step: remainder stays below the divisor, so 7 bits suffice.
   always_comb begin
      trial    = {rem, quo[COUNT_WIDTH-1]};
      fits     = (trial >= {1'b0, divisor});
      rem_next = fits ? 7'(trial - {1'b0, divisor}) : trial[6:0];
   end

   always_ff @(posedge clockSignal) begin
      if (reset) begin
         quo     <= '0;
         rem     <= '0;
         step    <= '0;
         cs_rem  <= '0;
         sec_rem <= '0;
         min_rem <= '0;
         hr_rem  <= '0;
         done_q  <= 1'b0;
         cs_out  <= '0;
         sec_out <= '0;
         min_out <= '0;
         hr_out  <= '0;
         day_out <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.convert) begin
                  quo  <= bus.countIn;
                  rem  <= '0;
                  step <= '0;
               end
            end
            DIV100, DIV60S, DIV60M, DIV24: begin
               // Quotient shifts into the dividend register, leaving it as the next stage's dividend.
               quo <= {quo[COUNT_WIDTH-2:0], fits};
               if (last) begin
                  rem  <= '0;
                  step <= '0;
                  case (state)
                     DIV100:  cs_rem  <= rem_next;
                     DIV60S:  sec_rem <= rem_next[5:0];
                     DIV60M:  min_rem <= rem_next[5:0];
                     default: hr_rem  <= rem_next[4:0];
                  endcase
               end else begin
                  rem  <= rem_next;
                  step <= step + 7'd1;
               end
            end
            FINISH: begin
               cs_out  <= cs_rem;
               sec_out <= sec_rem;
               min_out <= min_rem;
               hr_out  <= hr_rem;
               day_out <= quo;
               done_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy                = busy;
   assign bus.done                = done_q;
   assign bus.centisecondsDisplay = cs_out;
   assign bus.secondsDisplay      = sec_out;
   assign bus.minutesDisplay      = min_out;
   assign bus.hoursDisplay        = hr_out;
   assign bus.daysDisplay         = day_out;
endmodule

// File: tb/tb_centisecond_to_clock_display.sv
// Self-checking bench for centisecond_to_clock_display: directed cases plus random counts
// checked against an arithmetic time-of-day model.
module tb_centisecond_to_clock_display;
   localparam int unsigned W   = 40;
   localparam int          LAT = 4 * W + 1;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   longint unsigned prev[5];
   longint unsigned mask;
   string names[5] = '{"cs", "s", "m", "h", "d"};

   centisecond_to_clock_display_if #(.COUNT_WIDTH(W)) bus ();

   centisecond_to_clock_display #(.COUNT_WIDTH(W)) dut (
      .clockSignal(clk),
      .reset      (rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   function automatic longint unsigned model(input longint unsigned c, input int unsigned idx);
      case (idx)
         0:       return c % 100;
         1:       return (c / 100) % 60;
         2:       return (c / 6000) % 60;
         3:       return (c / 360000) % 24;
         default: return c / 8640000;
      endcase
   endfunction

   function automatic longint unsigned observed(input int unsigned idx);
      case (idx)
         0:       return longint'(bus.centisecondsDisplay);
         1:       return longint'(bus.secondsDisplay);
         2:       return longint'(bus.minutesDisplay);
         3:       return longint'(bus.hoursDisplay);
         default: return longint'(bus.daysDisplay);
      endcase
   endfunction

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
      end
   endtask

   task automatic quiet(input int cycles, input string tag);
      int dones = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (bus.done !== 1'b0) dones++;
      end
      check({tag, "_no_done"}, longint'(dones), 0);
   endtask

   // Called at a negedge; returns at the negedge where done is observed (or the bound expires).
   task automatic run(input longint unsigned value, input string tag,
                      input int pulse_at, input longint unsigned pulse_val);
      int done_at = -1;
      int bad_busy = 0;
      int bad_hold = 0;
      bus.countIn = value[W-1:0];
      bus.convert = 1'b1;
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad_busy++;
      bus.convert = 1'b0;
      bus.countIn = W'({$urandom, $urandom});
      for (int j = 1; j <= LAT + 20 && done_at < 0; j++) begin
         if (j == pulse_at) begin
            bus.convert = 1'b1;
            bus.countIn = pulse_val[W-1:0];
         end
         @(negedge clk);
         bus.convert = 1'b0;
         if (bus.done === 1'b1) done_at = j;
         else begin
            if (bus.busy !== 1'b1) bad_busy++;
            for (int unsigned i = 0; i < 5; i++)
               if (observed(i) !== prev[i]) bad_hold++;
         end
      end
      check({tag, "_latency"}, longint'(done_at), longint'(LAT));
      check({tag, "_busy_with_done"}, longint'(bus.busy), 0);
      check({tag, "_busy_during"}, longint'(bad_busy), 0);
      check({tag, "_hold"}, longint'(bad_hold), 0);
      for (int unsigned i = 0; i < 5; i++) begin
         check({tag, "_", names[i]}, observed(i), model(value, i));
         prev[i] = model(value, i);
      end
   endtask

   initial begin
      longint unsigned v;
      mask = (64'd1 << W) - 1;
      for (int unsigned i = 0; i < 5; i++) prev[i] = 0;
      rst = 1'b1;
      bus.convert = 1'b0;
      bus.countIn = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_done", longint'(bus.done), 0);
      for (int unsigned i = 0; i < 5; i++) check({"rst_", names[i]}, observed(i), 0);
      rst = 1'b0;

      run(64'd359999, "hour_edge", 0, 0);
      run(64'd8640000, "one_day", 0, 0);
      run(64'd8639999, "b2b_day_minus", 0, 0);
      run(mask, "all_ones", 0, 0);
      run(64'd500, "ignore_busy", 10, 64'd0);
      quiet(200, "ignore_busy");

      bus.countIn = W'(64'd8640000);
      bus.convert = 1'b1;
      @(negedge clk);
      bus.convert = 1'b0;
      repeat (49) @(negedge clk);
      check("abort_busy_before", longint'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", longint'(bus.busy), 0);
      check("abort_done", longint'(bus.done), 0);
      for (int unsigned i = 0; i < 5; i++) begin
         check({"abort_", names[i]}, observed(i), 0);
         prev[i] = 0;
      end
      rst = 1'b0;
      quiet(300, "abort");

      run(64'd123456789, "post_reset", 0, 0);
      run(64'd0, "zero", 0, 0);
      run(mask, "all_ones_again", 0, 0);

      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 3))
            0:       v = {32'($urandom), 32'($urandom)} & mask;
            1:       v = 64'($urandom_range(0, 999999));
            2:       v = 64'($urandom_range(0, 20000)) * 64'd8640000 + 64'($urandom_range(0, 2)) - 64'd1;
            default: v = mask - 64'($urandom_range(0, 1000));
         endcase
         if (v > mask) v = 0;
         run(v, $sformatf("rnd%0d", n), 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
